dbus_sram_responder: RTL and testbench
======================================

# dbus_sram_responder

Data-bus slave that answers the CPU memory stage's `dbus_req_t` requests with `dbus_resp_t` handshakes, backed by an internal byte-writable word memory. It sits on the far side of the data bus from the memory stage. It is the single-cycle/fixed-latency memory model used in simulation, and the on-chip scratch RAM in FPGA builds. It implements the `addr_ok`/`data_ok` split handshake, with configurable data latency and an external address-stall input for back-pressure testing.

## Interface
Parameters:
- `MEM_WORDS`, 1024: memory depth in 32-bit words; power of two.
- `LATENCY`, 1: cycles from the `addr_ok` cycle to the `data_ok` cycle; 0 means `addr_ok` and `data_ok` are asserted in the same cycle.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `dreq`  in  `dbus_req_t`  request: `valid`, `addr`, `size`, `strobe[3:0]`, `data[31:0]`.
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data[31:0]`.
- `stall`  in  1  when 1, `addr_ok` is suppressed (no new acceptance).
- `req_count`  out  32  number of completed transactions, i.e. `data_ok` pulses.

## Operation
- Word index = `dreq.addr[2 +: $clog2(MEM_WORDS)]`.
  - Upper bits are ignored, so addresses wrap modulo the memory size.
  - `addr[1:0]` and `size` are not used for indexing.
- Write vs read: a request is a write iff `strobe != 0`.
  - Write: byte lane i is updated from `data[8i+7:8i]` when `strobe[i]` is set; unset lanes are preserved.
  - Read: returns the full aligned word. The initiator does lane extraction and sign extension.
- Alignment is the initiator's responsibility. This block never faults.
- FSM states (`dresp_state_t`):
  - `DR_IDLE`:
    - `addr_ok = dreq.valid && !stall`.
    - On acceptance, the write commits at the accepting edge, or the read word is captured at that edge (read-before-write is not possible; a read sees all earlier writes).
    - If `LATENCY == 0`: `data_ok = addr_ok` in the same cycle, `dresp.data` = combinational read of the current memory, and the state stays `DR_IDLE`.
    - Else: go to `DR_WAIT`, with `cnt = LATENCY`.
  - `DR_WAIT`:
    - `addr_ok = 0`. `dreq` is ignored, even though the initiator keeps `valid` high while waiting.
    - `cnt` decrements each cycle.
    - `data_ok = (cnt == 1)`. In that cycle, `dresp.data` = the captured word (write responses return the post-write word); then go to `DR_IDLE`.
- No acceptance happens in a `data_ok` cycle when `LATENCY ≥ 1`. The earliest next acceptance is the following cycle.
- `req_count` increments on every `data_ok` cycle and wraps at 2^32.

## Timing
- Reset values:
  - state `DR_IDLE`; `cnt` 0; captured data 0; `req_count` 0.
  - `dresp.addr_ok`, `dresp.data_ok`, `dresp.data` are all 0 during and immediately after reset.
  - Memory contents are not reset.
- Reset asserted mid-transaction: the pending response is dropped and no `data_ok` is issued. A write already committed at its acceptance edge stays committed.
- `addr_ok` is combinational from `dreq.valid` and `stall` only in `DR_IDLE`. `data_ok` is registered-state-driven when `LATENCY ≥ 1`.
- Throughput:
  - `LATENCY = 0`: one transaction per cycle.
  - `LATENCY = L ≥ 1`: one transaction per L+1 cycles.
- `stall` takes effect in the same cycle and has no effect in `DR_WAIT`.

## Structure
- Shared package additions: `dresp_state_t` enum {`DR_IDLE`, `DR_WAIT`}.
- `dbus_req_t` and `dbus_resp_t` are already in the common header and are reused unchanged.
- One sub-module, `dbus_bram`: `MEM_WORDS`×32 array with a 4-bit byte-write enable, a synchronous write port, and a combinational read port.
- The FSM, latency counter, capture register and `req_count` live in the top module.

## Test plan
- `LATENCY=1`, write `0x11223344` to `0x100` with strobe `4'hF`, then read `0x100`:
  - write: `addr_ok` in cycle 0, `data_ok` in cycle 1;
  - read: `dresp.data = 0x11223344`;
  - `req_count = 2`.
- Byte write `data=0x0000AB00`, strobe `4'b0010` to `0x100`, then read: `0x1122AB44`.
- `LATENCY=0`, back-to-back reads over 4 consecutive cycles: `addr_ok` and `data_ok` are high every cycle, with correct data each cycle.
- `LATENCY=3`, `valid` held high throughout:
  - `addr_ok` exactly once;
  - `data_ok` 3 cycles later;
  - no second `addr_ok` in the `data_ok` cycle.
- `stall=1` for 2 cycles with `valid` high: no `addr_ok`; `addr_ok` appears in the cycle `stall` drops.
- Reset mid-`DR_WAIT` (`LATENCY=3`) after a write to `0x4`:
  - no `data_ok` appears;
  - a later read of `0x4` returns the written word;
  - `req_count` restarts at 0.

Source files
------------

// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder: bus request/response
// structs, the responder state encoding and a byte-lane merge helper.
package dbus_sram_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [0:0] {
    DR_IDLE = 1'b0,
    DR_WAIT = 1'b1
  } dresp_state_t;

  // Replace the byte lanes of old_word selected by strobe with new_word's lanes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus handshake bundle: request from the memory stage, response back,
// plus the address-stall input used to apply back-pressure.
interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       stall;

  modport master (output dreq, output stall, input dresp);
  modport slave  (input dreq, input stall, output dresp);

endinterface

// File: rtl/dbus_sram_responder_bram.sv
// Word memory with per-byte write enables, synchronous write and
// combinational read on a single shared address. Contents are not reset.
module dbus_bram
  import dbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Byte-lane write at the clock edge; unselected lanes keep their value.
  always_ff @(posedge clk) begin
    if (|we) mem[addr] <= merge_bytes(mem[addr], wdata, we);
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus slave with addr_ok/data_ok split handshake and a fixed data
// latency, backed by dbus_bram.
//
//   state   | meaning
//   DR_IDLE | ready to accept; with LATENCY 0 also answers in the same cycle
//   DR_WAIT | request accepted, counting down to the data_ok cycle
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  dbus_sram_responder_if.slave  bus,
  output logic [31:0]           req_count
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  localparam logic [0:0] ST_IDLE = 1'(DR_IDLE);
  localparam logic [0:0] ST_WAIT = 1'(DR_WAIT);

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   cap_q;
  logic [31:0]   req_count_q;

  logic          accept;
  logic          is_write;
  logic          data_ok;
  logic [3:0]    be;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [AW-1:0] word_idx;

  // Byte offset, size and address bits above the memory are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.dreq.size, bus.dreq.addr[1:0], bus.dreq.addr[31:2+AW]};

  assign word_idx = bus.dreq.addr[2 +: AW];
  assign is_write = |bus.dreq.strobe;
  assign accept   = resetn && (state_q == ST_IDLE) && bus.dreq.valid && !bus.stall;
  assign be       = accept ? bus.dreq.strobe : 4'h0;
  assign wr_word  = merge_bytes(rd_word, bus.dreq.data, bus.dreq.strobe);

  dbus_bram #(.MEM_WORDS(MEM_WORDS)) u_bram (
    .clk   (clk),
    .addr  (word_idx),
    .we    (be),
    .wdata (bus.dreq.data),
    .rdata (rd_word)
  );

  // Response outputs; data is forced to zero outside data_ok cycles.
  always_comb begin
    data_ok = 1'b0;
    if (LATENCY == 0) data_ok = accept;
    else              data_ok = resetn && (state_q == ST_WAIT) && (cnt_q == CW'(1));
    bus.dresp.addr_ok = accept;
    bus.dresp.data_ok = data_ok;
    bus.dresp.data    = '0;
    if (data_ok) bus.dresp.data = (LATENCY == 0) ? rd_word : cap_q;
  end

  // State, latency down-counter and capture of the (post-write) word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (LATENCY != 0)) begin
            state_q <= ST_WAIT;
            cnt_q   <= CW'(LATENCY);
            cap_q   <= is_write ? wr_word : rd_word;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completed-transaction counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!resetn)      req_count_q <= '0;
    else if (data_ok) req_count_q <= req_count_q + 32'd1;
  end

  assign req_count = req_count_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: three responders (LATENCY 1, 0 and 3) share a clock and reset.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic        clk;
  logic        resetn;
  logic [31:0] cnt1, cnt0, cnt3;
  int          checks;
  int          failures;

  dbus_sram_responder_if b1 ();
  dbus_sram_responder_if b0 ();
  dbus_sram_responder_if b3 ();

  dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(b1), .req_count(cnt1));
  dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(b0), .req_count(cnt0));
  dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .bus(b3), .req_count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic dbus_req_t mk(input logic v, input logic [31:0] a,
                                   input logic [3:0] s, input logic [31:0] d);
    dbus_req_t r;
    r = '0;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'd2;
    r.strobe = s;
    r.data   = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int aok_cnt;
    int dok_cnt;
    int dok_cyc;
    logic [31:0] l3_data;
    logic aok_in_dok;
    logic dok_seen;

    checks = 0;
    failures = 0;
    resetn = 1'b0;
    b1.dreq = '0; b1.stall = 1'b0;
    b0.dreq = '0; b0.stall = 1'b0;
    b3.dreq = '0; b3.stall = 1'b0;

    // Reset: outputs quiet even with valid high
    tick(); tick();
    b1.dreq = mk(1'b1, 32'h100, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_addr_ok", 32'(b1.dresp.addr_ok), 32'd0);
    chk("rst_data_ok", 32'(b1.dresp.data_ok), 32'd0);
    chk("rst_data", b1.dresp.data, 32'h0);
    chk("rst_req_count", cnt1, 32'd0);
    tick();
    resetn = 1'b1;
    b1.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_addr_ok", 32'(b1.dresp.addr_ok), 32'd0);

    // LATENCY 1: full-word write then read
    tick(); b1.dreq = mk(1'b1, 32'h100, 4'hF, 32'h11223344);
    @(negedge clk);
    chk("l1_wr_addr_ok", 32'(b1.dresp.addr_ok), 32'd1);
    chk("l1_wr_no_data_ok", 32'(b1.dresp.data_ok), 32'd0);
    tick(); b1.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l1_wr_data_ok", 32'(b1.dresp.data_ok), 32'd1);
    chk("l1_wr_wait_addr_ok", 32'(b1.dresp.addr_ok), 32'd0);
    chk("l1_wr_data", b1.dresp.data, 32'h11223344);
    tick(); b1.dreq = mk(1'b1, 32'h100, 4'h0, 32'h0);
    @(negedge clk);
    chk("l1_rd_addr_ok", 32'(b1.dresp.addr_ok), 32'd1);
    chk("l1_count_1", cnt1, 32'd1);
    tick(); b1.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l1_rd_data_ok", 32'(b1.dresp.data_ok), 32'd1);
    chk("l1_rd_data", b1.dresp.data, 32'h11223344);

    // LATENCY 1: byte write to lane 1, then read through a wrapped address
    tick(); b1.dreq = mk(1'b1, 32'h100, 4'b0010, 32'h0000AB00);
    @(negedge clk);
    chk("l1_count_2", cnt1, 32'd2);
    chk("l1_bw_addr_ok", 32'(b1.dresp.addr_ok), 32'd1);
    tick(); b1.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l1_bw_data_ok", 32'(b1.dresp.data_ok), 32'd1);
    chk("l1_bw_post_word", b1.dresp.data, 32'h1122AB44);
    tick(); b1.dreq = mk(1'b1, 32'h1100, 4'h0, 32'h0);
    @(negedge clk);
    chk("l1_wrap_addr_ok", 32'(b1.dresp.addr_ok), 32'd1);
    tick(); b1.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l1_wrap_rd_data", b1.dresp.data, 32'h1122AB44);
    tick();
    @(negedge clk);
    chk("l1_count_4", cnt1, 32'd4);

    // LATENCY 0: four back-to-back writes, then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      tick(); b0.dreq = mk(1'b1, 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i));
      @(negedge clk);
      chk("l0_wr_addr_ok", 32'(b0.dresp.addr_ok), 32'd1);
      chk("l0_wr_data_ok", 32'(b0.dresp.data_ok), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); b0.dreq = mk(1'b1, 32'(4 * i), 4'h0, 32'h0);
      @(negedge clk);
      chk("l0_rd_addr_ok", 32'(b0.dresp.addr_ok), 32'd1);
      chk("l0_rd_data_ok", 32'(b0.dresp.data_ok), 32'd1);
      chk("l0_rd_data", b0.dresp.data, 32'hA0000000 + 32'(i));
    end
    tick(); b0.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l0_count_8", cnt0, 32'd8);

    // LATENCY 0: stall blocks acceptance for two cycles, releases same cycle
    tick(); b0.stall = 1'b1; b0.dreq = mk(1'b1, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("stall_c0_addr_ok", 32'(b0.dresp.addr_ok), 32'd0);
    chk("stall_c0_data_ok", 32'(b0.dresp.data_ok), 32'd0);
    tick();
    @(negedge clk);
    chk("stall_c1_addr_ok", 32'(b0.dresp.addr_ok), 32'd0);
    tick(); b0.stall = 1'b0;
    @(negedge clk);
    chk("unstall_addr_ok", 32'(b0.dresp.addr_ok), 32'd1);
    chk("unstall_data_ok", 32'(b0.dresp.data_ok), 32'd1);
    chk("unstall_data", b0.dresp.data, 32'hA0000000);
    tick(); b0.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l0_count_9", cnt0, 32'd9);

    // LATENCY 3: valid held high across the whole transaction
    aok_cnt = 0; dok_cnt = 0; dok_cyc = -1; l3_data = '0; aok_in_dok = 1'b0;
    tick(); b3.dreq = mk(1'b1, 32'h8, 4'hF, 32'hCAFEF00D);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (b3.dresp.addr_ok) aok_cnt++;
      if (b3.dresp.data_ok) begin
        dok_cnt++;
        dok_cyc = c;
        l3_data = b3.dresp.data;
        aok_in_dok = b3.dresp.addr_ok;
      end
    end
    tick(); b3.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    chk("l3_addr_ok_once", 32'(aok_cnt), 32'd1);
    chk("l3_data_ok_once", 32'(dok_cnt), 32'd1);
    chk("l3_data_ok_cycle", 32'(dok_cyc), 32'd3);
    chk("l3_no_addr_ok_in_data_ok", 32'(aok_in_dok), 32'd0);
    chk("l3_data", l3_data, 32'hCAFEF00D);
    @(negedge clk);
    chk("l3_count_1", cnt3, 32'd1);

    // LATENCY 3: reset during DR_WAIT after a write to 0x4
    tick(); b3.dreq = mk(1'b1, 32'h4, 4'hF, 32'h5A5AA5A5);
    @(negedge clk);
    chk("l3_rst_wr_addr_ok", 32'(b3.dresp.addr_ok), 32'd1);
    tick(); b3.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0); resetn = 1'b0;
    @(negedge clk);
    dok_seen = b3.dresp.data_ok;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 1) resetn = 1'b1;
      @(negedge clk);
      dok_seen = dok_seen | b3.dresp.data_ok;
    end
    chk("l3_rst_no_data_ok", 32'(dok_seen), 32'd0);
    chk("l3_rst_count_0", cnt3, 32'd0);
    tick(); b3.dreq = mk(1'b1, 32'h4, 4'h0, 32'h0);
    @(negedge clk);
    chk("l3_rst_rd_addr_ok", 32'(b3.dresp.addr_ok), 32'd1);
    tick(); b3.dreq = mk(1'b0, 32'h0, 4'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("l3_rst_rd_data_ok", 32'(b3.dresp.data_ok), 32'd1);
    chk("l3_rst_rd_data", b3.dresp.data, 32'h5A5AA5A5);
    tick();
    @(negedge clk);
    chk("l3_rst_count_1", cnt3, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
